// File: rtl/sr_cell_pkg.sv
// Shared types and constants for the SR cell write arbiter.
package sr_cell_pkg;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      PULSE = 3'd2,
      GAP   = 3'd3,
      CHECK = 3'd4
   } state_t;

   localparam logic OP_LOW  = 1'b0;
   localparam logic OP_HIGH = 1'b1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above the pointer, with wrap.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx
);

   logic found;
   int   k;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         k = (int'(ptr) + i) % N_REQ;
         if (en && !found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/sr_cell_arbiter.sv
// Shares one SR cell among N_REQ requesters: pulse write, settle gap, readback check.
module sr_cell_arbiter
   import sr_cell_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] op,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] done,
   output logic             s,
   output logic             r,
   input  logic             q_in,
   input  logic             qb_in,
   output logic             busy,
   output logic             err
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(max2(PULSE_W, GAP_W) + 1);

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             init_gap, init_gap_n;
   logic [IW-1:0]    ptr, ptr_n, idx, idx_n, arb_idx;
   logic             opl, opl_n;
   logic             arb_en;
   logic [N_REQ-1:0] arb_gnt, gnt_n, done_n;
   logic             s_n, r_n, err_n;

   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req (req),
      .ptr (ptr),
      .en  (arb_en),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      state_n    = state;
      cnt_n      = cnt + CW'(1);
      init_gap_n = init_gap;
      ptr_n      = ptr;
      idx_n      = idx;
      opl_n      = opl;
      gnt_n      = gnt;
      done_n     = '0;
      err_n      = err;
      arb_en     = 1'b0;
      case (state)
         // cnt starts at 0 from reset, so the pulse phase spans the reset cycle plus PULSE_W
         INIT: begin
            if (!init_gap) begin
               if (cnt == CW'(PULSE_W)) begin
                  init_gap_n = 1'b1;
                  cnt_n      = CW'(1);
               end
            end else if (cnt == CW'(GAP_W)) begin
               state_n = IDLE;
               cnt_n   = CW'(1);
            end
         end
         IDLE: begin
            arb_en = 1'b1;
            cnt_n  = cnt;
            if (|req) begin
               state_n = PULSE;
               cnt_n   = CW'(1);
               idx_n   = arb_idx;
               ptr_n   = arb_idx;
               opl_n   = op[arb_idx];
               gnt_n   = arb_gnt;
            end
         end
         PULSE: begin
            if (cnt == CW'(PULSE_W)) begin
               state_n = GAP;
               cnt_n   = CW'(1);
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_W)) begin
               state_n     = CHECK;
               cnt_n       = CW'(1);
               done_n[idx] = 1'b1;
               // cell has settled by the end of the gap; flag is visible during CHECK
               if ((q_in != opl) || (qb_in != ~opl)) err_n = 1'b1;
            end
         end
         CHECK: begin
            state_n = IDLE;
            cnt_n   = CW'(1);
            gnt_n   = '0;
         end
         default: begin
            state_n = INIT;
            cnt_n   = '0;
         end
      endcase
      s_n = ((state_n == INIT) && !init_gap_n) || ((state_n == PULSE) && (opl_n == OP_LOW));
      r_n = (state_n == PULSE) && (opl_n == OP_HIGH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         cnt      <= '0;
         init_gap <= 1'b0;
         ptr      <= IW'(N_REQ - 1);
         idx      <= '0;
         opl      <= OP_LOW;
         gnt      <= '0;
         done     <= '0;
         s        <= 1'b0;
         r        <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         init_gap <= init_gap_n;
         ptr      <= ptr_n;
         idx      <= idx_n;
         opl      <= opl_n;
         gnt      <= gnt_n;
         done     <= done_n;
         s        <= s_n;
         r        <= r_n;
         err      <= err_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_cell_arbiter.sv
// Randomized bench for sr_cell_arbiter with a transaction-level round-robin/cell model.
module tb_sr_cell_arbiter;

   localparam int N = 4;
   localparam int P = 2;
   localparam int G = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req, op, gnt, done;
   logic         s, r, busy, err;
   logic         cq = 1'b1;
   logic         stuck = 1'b0;

   int npass = 0;
   int nchk  = 0;
   int model_last;
   bit model_err;

   sr_cell_arbiter #(.N_REQ(N), .PULSE_W(P), .GAP_W(G)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .op    (op),
      .gnt   (gnt),
      .done  (done),
      .s     (s),
      .r     (r),
      .q_in  (cq),
      .qb_in (~cq),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   // behavioural SR cell; stuck models a cell that will not leave q=0
   always @(posedge clk) begin
      if (stuck)  cq <= 1'b0;
      else if (s) cq <= 1'b0;
      else if (r) cq <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
   endtask

   always @(negedge clk) chk("s_r_excl", 32'(s & r), 0);

   assert property (@(posedge clk) !(s && r)) else $error("s and r high together");

   function automatic int rr_pick(input logic [N-1:0] rq, input int last);
      int k;
      for (int i = 1; i <= N; i++) begin
         k = (last + i) % N;
         if (rq[k]) return k;
      end
      return -1;
   endfunction

   // assert reset now, check reset outputs, release and observe the clear write
   task automatic reset_init();
      int s_cnt, b_cnt;
      bit g_seen, d_seen, r_seen;
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("rst_s", 32'(s), 0);
      chk("rst_r", 32'(r), 0);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 1);
      @(negedge clk);
      chk("rst_hold_done", 32'(done), 0);
      rst_n = 1'b1;
      model_last = N - 1;
      model_err  = 1'b0;
      s_cnt = 0; b_cnt = 0; g_seen = 0; d_seen = 0; r_seen = 0;
      for (int k = 1; k <= P + G + 3; k++) begin
         @(negedge clk);
         s_cnt += int'(s);
         b_cnt += int'(busy);
         g_seen |= |gnt;
         d_seen |= |done;
         r_seen |= r;
      end
      chk("init_s_cycles", 32'(s_cnt), P);
      chk("init_busy_cycles", 32'(b_cnt), P + G);
      chk("init_gnt", 32'(g_seen), 0);
      chk("init_done", 32'(d_seen), 0);
      chk("init_r", 32'(r_seen), 0);
      chk("init_err", 32'(err), 0);
      chk("init_cell_q", 32'(cq), 0);
   endtask

   // called at an IDLE-cycle sample; follows one full write and ends at the next IDLE sample
   task automatic watch_op(input logic [N-1:0] drop_mask, input bit keep_after,
                           output int who, output int waited);
      logic [N-1:0] rq_s, op_s, oh;
      int  exp;
      bit  e_op, bad;
      who = -1;
      waited = 0;
      rq_s = req;
      op_s = op;
      while (gnt == '0 && waited < 40) begin
         rq_s = req;
         op_s = op;
         @(negedge clk);
         waited++;
      end
      if (gnt == '0) begin
         chk("gnt_timeout", 0, 1);
         return;
      end
      exp = rr_pick(rq_s, model_last);
      if (exp < 0) begin
         chk("unrequested_gnt", 32'(gnt), 0);
         return;
      end
      oh = '0;
      oh[exp] = 1'b1;
      chk("winner", 32'(gnt), 32'(oh));
      e_op = op_s[exp];
      bad  = stuck && e_op;
      model_last = exp;
      who = exp;
      for (int k = 0; k <= P + G; k++) begin
         if (k == 0) req &= ~drop_mask;
         chk("op_s", 32'(s), 32'((k < P) && !e_op));
         chk("op_r", 32'(r), 32'((k < P) && e_op));
         chk("op_gnt", 32'(gnt), 32'(oh));
         chk("op_done", 32'(done), (k == P + G) ? 32'(oh) : 0);
         chk("op_busy", 32'(busy), 1);
         if (k == P + G) begin
            model_err |= bad;
            chk("op_err", 32'(err), 32'(model_err));
            if (!keep_after) req[exp] = 1'b0;
         end
         @(negedge clk);
      end
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("cell_q", 32'(cq), 32'(bad ? 1'b0 : e_op));
   endtask

   initial begin
      int who, w, t;
      rst_n = 1'b0;
      req   = '0;
      op    = '0;
      @(negedge clk);
      reset_init();

      req = 4'b0001; op = 4'b0001;
      watch_op('0, 1'b0, who, w);
      chk("single_who", 32'(who), 0);

      reset_init();
      req = 4'b1111; op = 4'($urandom);
      for (int i = 0; i < 5; i++) begin
         watch_op('0, 1'b1, who, w);
         chk("rr_order", 32'(who), 32'(i % N));
         if (i > 0) chk("rr_idle_gap", 32'(w), 1);
      end
      req = '0;

      stuck = 1'b1;
      req = 4'b0010; op = 4'b0010;
      watch_op('0, 1'b0, who, w);
      stuck = 1'b0;
      req = 4'b0100; op = 4'b0100;
      watch_op('0, 1'b0, who, w);
      req = 4'b0001; op = 4'b0000;
      watch_op('0, 1'b0, who, w);
      chk("err_sticky", 32'(err), 1);
      reset_init();
      chk("err_cleared", 32'(err), 0);

      req = 4'b1100; op = 4'($urandom);
      watch_op(4'b0100, 1'b0, who, w);
      chk("drop_who", 32'(who), 2);
      watch_op('0, 1'b0, who, w);
      chk("after_drop", 32'(who), 3);

      for (int i = 0; i < 40; i++) begin
         if (req == '0) req = 4'($urandom_range(1, 15));
         else           req |= 4'($urandom);
         op = 4'($urandom);
         watch_op(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  1'($urandom), who, w);
      end

      req = 4'b0001; op = 4'b0001;
      t = 0;
      while (gnt == '0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("abort_gnt", 32'(gnt), 1);
      @(negedge clk);
      chk("abort_r_before", 32'(r), 1);
      reset_init();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
